// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the configurable UART blocks (receiver now, transmitter later).
//   PAR_NONE/PAR_EVEN/PAR_ODD : values of the 2-bit parity-mode field (2'b11 also means none)
//   uart_state_e              : receiver state encoding
//   maj3()                    : 2-of-3 majority used by the bit voter
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if
// Receive-side valid/ready handshake carrying one frame to the consumer.
//   rx_valid : frame held in rx_dout/rx_perr/rx_ferr
//   rx_dout  : received data (DBIT wide)
//   rx_perr  : parity error of held frame
//   rx_ferr  : stop-bit error of held frame
//   rx_ready : consumer accepts the held frame
// master = receiver, slave = consumer.
interface uart_rx_cfg_if #(parameter int DBIT = 8);

    logic            rx_valid;
    logic [DBIT-1:0] rx_dout;
    logic            rx_perr;
    logic            rx_ferr;
    logic            rx_ready;

    modport master (output rx_valid, rx_dout, rx_perr, rx_ferr, input rx_ready);
    modport slave  (input rx_valid, rx_dout, rx_perr, rx_ferr, output rx_ready);

endinterface

// File: rtl/uart_rx_cfg_baud_tick_gen.sv
// baud_tick_gen
// Free-running oversample tick generator: counts 0..divisor-1 and asserts tick on
// the last count. A divisor of 0 behaves as 1 (tick every clock).
//   clk, reset_n : clock, async active-low reset
//   divisor      : clocks per tick
//   tick         : one-clock pulse every max(divisor,1) clocks
module baud_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] last_cnt;

    assign last_cnt = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    // >= so a divisor that shrinks below the current count wraps at once
    assign tick     = (cnt_q >= last_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg
// Runtime-configurable UART receiver: oversampled, 3-sample majority vote, optional
// parity, 1 or 2 stop bits, break detection, one-entry valid/ready output register.
//   clk, reset_n           : clock, async active-low reset
//   rx                     : asynchronous serial input, idle high
//   divisor                : clocks per oversample tick (0 acts as 1)
//   cfg_parity, cfg_stop2  : frame format, latched at start-bit detection
//   rx_if (master)         : rx_valid/rx_dout/rx_perr/rx_ferr out, rx_ready in
//   overrun_err            : 1-clock pulse, completed frame dropped
//   break_det              : 1-clock pulse, break condition seen
//   rx_busy                : receiver not idle
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a 1->0 transition of the synchronised line
// ST_START   | qualifying the start bit; a high mid-bit vote is a glitch
// ST_DATA    | shifting in DBIT data bits, LSB first
// ST_PARITY  | checking the parity bit against the data
// ST_STOP    | deciding stop bit(s) at mid-bit + 1 sample
// ST_WAIT_HI | after a framing error/break, waiting for the line to go high
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT  = 8,
    parameter int OS    = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    uart_rx_cfg_if.master    rx_if,
    output logic             overrun_err,
    output logic             break_det,
    output logic             rx_busy
);

    localparam int SW = $clog2(OS);
    localparam int BW = $clog2(DBIT + 1);

    localparam logic [SW-1:0] S_MID0 = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_MID1 = SW'(OS / 2);
    localparam logic [SW-1:0] S_MID2 = SW'(OS / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

    logic             rx_s1_q, rx_s2_q;
    logic             rx_sync;

    uart_state_e      state_q;
    logic [SW-1:0]    s_q;
    logic [BW-1:0]    bit_q;
    logic [DBIT-1:0]  data_q;
    logic             smp0_q, smp1_q, vote_q;
    logic             prev_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       par_q;
    logic             stop2_q, stop_idx_q;
    logic             perr_q, ferr_q, par_vote_q;
    logic             busy_q;

    logic             valid_q, out_perr_q, out_ferr_q, ovr_q, brk_q;
    logic [DIV_W-1:0] div_use;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] dout_q;
    logic [DBIT-1:0]  dout_d;

    logic             tick;
    logic             vote_now;
    logic             par_en;
    logic             stop_final;
    logic             ferr_fin;
    logic             is_break;
    logic             deliver;
    logic             brk_now;

    // ------------------------------------------------------------------
    // Input synchroniser (idles high so reset does not look like a start)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign rx_sync = rx_s2_q;

    // Live divisor while idle, frozen copy for the rest of the frame
    assign div_d   = divisor;
    assign div_use = (state_q == ST_IDLE) ? div_d : div_q;

    baud_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .divisor (div_use),
        .tick    (tick)
    );

    // Third sample is the live synchronised line at mid+1
    assign vote_now   = maj3(smp0_q, smp1_q, rx_sync);
    assign par_en     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign stop_final = tick && (state_q == ST_STOP) && (s_q == S_MID2)
                        && (!stop2_q || stop_idx_q);
    assign ferr_fin   = ferr_q | ~vote_now;
    // Break: the whole frame read as zero, including parity when present
    assign is_break   = ferr_fin && (data_q == '0) && (!par_en || !par_vote_q);
    assign deliver    = stop_final && !is_break;
    assign brk_now    = stop_final && is_break;

    // ------------------------------------------------------------------
    // Receive FSM (advances on ticks only)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            smp0_q     <= 1'b0;
            smp1_q     <= 1'b0;
            vote_q     <= 1'b0;
            prev_q     <= 1'b1;
            div_q      <= '0;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_vote_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (tick) begin
            if (s_q == S_MID0) smp0_q <= rx_sync;
            if (s_q == S_MID1) smp1_q <= rx_sync;

            case (state_q)
                ST_IDLE: begin
                    prev_q <= rx_sync;
                    if (prev_q && !rx_sync) begin
                        state_q    <= ST_START;
                        s_q        <= '0;
                        bit_q      <= '0;
                        busy_q     <= 1'b1;
                        div_q      <= div_d;
                        par_q      <= cfg_parity;
                        stop2_q    <= cfg_stop2;
                        stop_idx_q <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                        par_vote_q <= 1'b0;
                    end
                end

                ST_START: begin
                    s_q <= s_q + SW'(1);
                    if (s_q == S_MID2 && vote_now) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        s_q     <= '0;
                        prev_q  <= rx_sync;
                    end else if (s_q == S_LAST) begin
                        state_q <= ST_DATA;
                        s_q     <= '0;
                    end
                end

                ST_DATA: begin
                    s_q <= s_q + SW'(1);
                    if (s_q == S_MID2) vote_q <= vote_now;
                    if (s_q == S_LAST) begin
                        s_q    <= '0;
                        data_q <= {vote_q, data_q[DBIT-1:1]};
                        bit_q  <= bit_q + BW'(1);
                        if (bit_q == B_LAST) begin
                            state_q <= par_en ? ST_PARITY : ST_STOP;
                        end
                    end
                end

                ST_PARITY: begin
                    s_q <= s_q + SW'(1);
                    if (s_q == S_MID2) begin
                        par_vote_q <= vote_now;
                        // even expects XOR(data); odd expects its inverse
                        perr_q     <= vote_now ^ (^data_q) ^ (par_q == PAR_ODD);
                    end
                    if (s_q == S_LAST) begin
                        state_q <= ST_STOP;
                        s_q     <= '0;
                    end
                end

                ST_STOP: begin
                    s_q <= s_q + SW'(1);
                    if (stop_final) begin
                        // Decide early so back-to-back start bits are not missed
                        state_q <= ferr_fin ? ST_WAIT_HI : ST_IDLE;
                        busy_q  <= ferr_fin;
                        ferr_q  <= ferr_fin;
                        s_q     <= '0;
                        prev_q  <= rx_sync;
                    end else if (s_q == S_MID2) begin
                        ferr_q <= ferr_fin;
                    end else if (s_q == S_LAST) begin
                        stop_idx_q <= 1'b1;
                        s_q        <= '0;
                    end
                end

                ST_WAIT_HI: begin
                    if (rx_sync) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        prev_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    s_q     <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // One-entry output register
    // ------------------------------------------------------------------
    assign dout_d = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            dout_q     <= '0;
            out_perr_q <= 1'b0;
            out_ferr_q <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            ovr_q <= deliver && valid_q && !rx_if.rx_ready;
            brk_q <= brk_now;
            if (deliver && (!valid_q || rx_if.rx_ready)) begin
                valid_q    <= 1'b1;
                dout_q     <= DIV_W'(dout_d);
                out_perr_q <= perr_q;
                out_ferr_q <= ferr_fin;
            end else if (valid_q && rx_if.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.rx_valid = valid_q;
    assign rx_if.rx_dout  = dout_q[DBIT-1:0];
    assign rx_if.rx_perr  = out_perr_q;
    assign rx_if.rx_ferr  = out_ferr_q;
    assign overrun_err    = ovr_q;
    assign break_det      = brk_q;
    assign rx_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg
// Directed bench for uart_rx_cfg at divisor=27, OS=16 (432 clocks per bit).
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int BIT_CLK = 432;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        rx        = 1'b1;
    logic [15:0] divisor   = 16'd27;
    logic [1:0]  cfg_parity = PAR_NONE;
    logic        cfg_stop2 = 1'b0;
    logic        overrun_err, break_det, rx_busy;

    uart_rx_cfg_if #(.DBIT(8)) rx_if ();

    uart_rx_cfg #(.DBIT(8), .OS(16), .DIV_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .divisor     (divisor),
        .cfg_parity  (cfg_parity),
        .cfg_stop2   (cfg_stop2),
        .rx_if       (rx_if),
        .overrun_err (overrun_err),
        .break_det   (break_det),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int valid_cyc = 0, hs_cnt = 0, ovr_cyc = 0, brk_cyc = 0, busy_cyc = 0;
    logic [7:0] cap_dout = 8'h00;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;

    always @(negedge clk) begin
        if (rx_if.rx_valid === 1'b1) begin
            valid_cyc++;
            cap_dout = rx_if.rx_dout;
            cap_perr = rx_if.rx_perr;
            cap_ferr = rx_if.rx_ferr;
            if (rx_if.rx_ready === 1'b1) hs_cnt++;
        end
        if (overrun_err === 1'b1) ovr_cyc++;
        if (break_det === 1'b1) brk_cyc++;
        if (rx_busy === 1'b1) busy_cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    // A '1' bit with a one-tick (27-clock) low pulse near mid-bit
    task automatic drive_glitch();
        rx = 1'b1;
        repeat (230) @(posedge clk);
        rx = 1'b0;
        repeat (27) @(posedge clk);
        rx = 1'b1;
        repeat (BIT_CLK - 257) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                              input bit two_stop, input logic last_stop, input int glitch_idx);
        logic [7:0] dv;
        dv = d;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_idx) drive_glitch();
            else drive_bit(dv[i]);
        end
        if (has_par) drive_bit(pbit);
        if (two_stop) drive_bit(1'b1);
        drive_bit(last_stop);
        rx = 1'b1;
    endtask

    int v0, h0, o0, b0, k0;
    logic [7:0] d5a;

    initial begin
        rx_if.rx_ready = 1'b1;
        d5a = 8'h5A;

        // reset state
        #12;
        check("rst_valid", rx_if.rx_valid, 1'b0);
        check("rst_dout",  rx_if.rx_dout, 8'h00);
        check("rst_busy",  rx_busy, 1'b0);
        check("rst_ovr",   overrun_err, 1'b0);
        check("rst_brk",   break_det, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (500) @(posedge clk);

        // 0xA5 8N1
        v0 = valid_cyc;
        send_frame(8'hA5, 0, 1'b0, 0, 1'b1, -1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("a5_valid_cycles", valid_cyc - v0, 1);
        check("a5_dout", cap_dout, 8'hA5);
        check("a5_perr", cap_perr, 1'b0);
        check("a5_ferr", cap_ferr, 1'b0);
        check("a5_busy", rx_busy, 1'b0);

        // even parity, 0x07 with wrong parity bit 0
        cfg_parity = PAR_EVEN;
        v0 = valid_cyc;
        send_frame(8'h07, 1, 1'b0, 0, 1'b1, -1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("par0_valid_cycles", valid_cyc - v0, 1);
        check("par0_dout", cap_dout, 8'h07);
        check("par0_perr", cap_perr, 1'b1);

        // even parity, correct parity bit 1, glitch on data bit 0
        v0 = valid_cyc;
        send_frame(8'h07, 1, 1'b1, 0, 1'b1, 0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("par1_valid_cycles", valid_cyc - v0, 1);
        check("par1_glitch_dout", cap_dout, 8'h07);
        check("par1_perr", cap_perr, 1'b0);
        cfg_parity = PAR_NONE;

        // short low pulse: start-bit glitch reject
        v0 = valid_cyc;
        k0 = busy_cyc;
        rx = 1'b0;
        repeat (81) @(posedge clk);
        rx = 1'b1;
        repeat (800) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_seen", (busy_cyc != k0), 1'b1);
        check("glitch_no_valid", valid_cyc - v0, 0);
        check("glitch_busy_end", rx_busy, 1'b0);

        // overrun with consumer stalled
        rx_if.rx_ready = 1'b0;
        o0 = ovr_cyc;
        send_frame(8'h11, 0, 1'b0, 0, 1'b1, -1);
        send_frame(8'h22, 0, 1'b0, 0, 1'b1, -1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("ovr_valid_held", rx_if.rx_valid, 1'b1);
        check("ovr_dout_kept", rx_if.rx_dout, 8'h11);
        check("ovr_pulse_cycles", ovr_cyc - o0, 1);
        h0 = hs_cnt;
        @(posedge clk);
        #1 rx_if.rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_cleared", rx_if.rx_valid, 1'b0);
        check("ovr_handshakes", hs_cnt - h0, 1);

        // break: 12 bit times low
        v0 = valid_cyc;
        b0 = brk_cyc;
        rx = 1'b0;
        repeat (12 * BIT_CLK) @(posedge clk);
        @(negedge clk);
        check("brk_busy_while_low", rx_busy, 1'b1);
        check("brk_pulse_cycles", brk_cyc - b0, 1);
        rx = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("brk_busy_after_high", rx_busy, 1'b0);
        check("brk_no_valid", valid_cyc - v0, 0);
        check("brk_single_pulse", brk_cyc - b0, 1);

        v0 = valid_cyc;
        send_frame(8'h3C, 0, 1'b0, 0, 1'b1, -1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("post_brk_valid_cycles", valid_cyc - v0, 1);
        check("post_brk_dout", cap_dout, 8'h3C);
        check("post_brk_ferr", cap_ferr, 1'b0);

        // asynchronous reset inside data bit 3
        cfg_stop2 = 1'b1;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d5a[i]);
        rx = d5a[3];
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("mid_busy", rx_busy, 1'b1);
        check("mid_dout_prev", rx_if.rx_dout, 8'h3C);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", rx_busy, 1'b0);
        check("arst_dout", rx_if.rx_dout, 8'h00);
        check("arst_valid", rx_if.rx_valid, 1'b0);
        check("arst_ferr", rx_if.rx_ferr, 1'b0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (500) @(posedge clk);

        // 0x5A with two good stop bits
        v0 = valid_cyc;
        send_frame(8'h5A, 0, 1'b0, 1, 1'b1, -1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("stop2_valid_cycles", valid_cyc - v0, 1);
        check("stop2_dout", cap_dout, 8'h5A);
        check("stop2_ferr", cap_ferr, 1'b0);

        // 0x5A with second stop bit low
        v0 = valid_cyc;
        send_frame(8'h5A, 0, 1'b0, 1, 1'b0, -1);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("stop2bad_valid_cycles", valid_cyc - v0, 1);
        check("stop2bad_dout", cap_dout, 8'h5A);
        check("stop2bad_ferr", cap_ferr, 1'b1);
        check("stop2bad_busy_end", rx_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
